// File: rtl/data_mem_access_unit.sv
// -----------------------------------------------------------------------------
// data_mem_access_unit
//
// Sequential MEM-stage load/store unit. Accepts one request at a time over a
// valid/ready handshake, positions store data and byte strobes on the RAM
// lanes, drives a synchronous data RAM with RD_LATENCY cycles of read latency,
// and formats load data (shift, mask, sign/zero extension) into a one-cycle
// response.
//
// Configuration macro: MISALIGNED_SPLIT_EN
//   defined   : accesses crossing a word boundary run as two RAM beats
//               (ISSUE0 then ISSUE1, word+1 wraps modulo the address space).
//   undefined : such accesses are rejected with an error response.
//
// Parameters
//   NB_DATA     data/word width in bits (32 or 64)
//   NB_ADDR     byte-address width
//   RD_LATENCY  RAM read latency in cycles (1..4)
//
// Ports
//   i_clock       clock, rising edge
//   i_reset       asynchronous active-low reset
//   i_req_valid   request present
//   o_req_ready   unit idle and able to accept
//   i_mem_read    load request
//   i_mem_write   store request
//   i_signed      sign-extend load result
//   i_size        access size 2^i_size bytes
//   i_addr        byte address
//   i_write_data  store data, right-aligned
//   o_rsp_valid   one-cycle response strobe
//   o_read_data   formatted load data (0 for stores/errors), held between responses
//   o_error       request rejected (qualifies o_rsp_valid)
//   o_mem_en      RAM access enable
//   o_mem_we      RAM per-byte write strobes
//   o_mem_addr    RAM word address
//   o_mem_wdata   lane-positioned RAM write data
//   i_mem_rdata   RAM read data
// -----------------------------------------------------------------------------
module data_mem_access_unit #(
  parameter int NB_DATA    = 32,
  parameter int NB_ADDR    = 12,
  parameter int RD_LATENCY = 1
) (
  input  logic                                    i_clock,
  input  logic                                    i_reset,
  input  logic                                    i_req_valid,
  output logic                                    o_req_ready,
  input  logic                                    i_mem_read,
  input  logic                                    i_mem_write,
  input  logic                                    i_signed,
  input  logic [1:0]                              i_size,
  input  logic [NB_ADDR-1:0]                      i_addr,
  input  logic [NB_DATA-1:0]                      i_write_data,
  output logic                                    o_rsp_valid,
  output logic [NB_DATA-1:0]                      o_read_data,
  output logic                                    o_error,
  output logic                                    o_mem_en,
  output logic [NB_DATA/8-1:0]                    o_mem_we,
  output logic [NB_ADDR-$clog2(NB_DATA/8)-1:0]    o_mem_addr,
  output logic [NB_DATA-1:0]                      o_mem_wdata,
  input  logic [NB_DATA-1:0]                      i_mem_rdata
);

  localparam int NB_BYTES = NB_DATA / 8;
  localparam int NB_OFF   = $clog2(NB_BYTES);
  localparam int NB_WADDR = NB_ADDR - NB_OFF;
`ifdef MISALIGNED_SPLIT_EN
  localparam int NB_SPAN  = 2;
`else
  localparam int NB_SPAN  = 1;
`endif
  // Lane/data vectors span two words when the split path is built.
  localparam int NB_WIDE  = NB_SPAN * NB_DATA;
  localparam int NB_WLANE = NB_SPAN * NB_BYTES;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE0 = 3'd1,
    S_ISSUE1 = 3'd2,
    S_WAIT   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [1:0]            r_cnt;
  logic                  w_accept;
  logic                  w_cap_last;

  // Request decode (combinational, used only at acceptance)
  logic [NB_OFF-1:0]     w_in_off;
  logic [4:0]            w_in_nbytes;
  logic [4:0]            w_in_end;
  logic                  w_in_cross;
  logic                  w_in_err;
  logic [NB_WLANE-1:0]   w_in_lanes;
  logic [NB_WIDE-1:0]    w_in_wdata;

  // Registered request
  logic                  r_is_load;
  logic                  r_signed;
  logic [1:0]            r_size;
  logic [NB_OFF-1:0]     r_off;

`ifdef MISALIGNED_SPLIT_EN
  logic                  r_cross;
  logic [NB_WADDR-1:0]   r_waddr;
  logic [NB_BYTES-1:0]   r_we_hi;
  logic [NB_DATA-1:0]    r_wd_hi;
  logic [NB_DATA-1:0]    r_beat0;
  logic                  w_cap0;
`endif

  // Load formatting
  logic [NB_WIDE-1:0]    w_rd_wide;
  logic [NB_DATA-1:0]    w_rd_aligned;
  logic [NB_DATA-1:0]    w_rd_fmt;
  logic [4:0]            w_nbytes;
  logic                  w_sign;

  // Registered outputs
  logic                  r_req_ready;
  logic                  r_rsp_valid;
  logic                  r_error;
  logic [NB_DATA-1:0]    r_read_data;
  logic                  r_mem_en;
  logic [NB_BYTES-1:0]   r_mem_we;
  logic [NB_WADDR-1:0]   r_mem_addr;
  logic [NB_DATA-1:0]    r_mem_wdata;

  // Decode the incoming request: error classes, word crossing, lane strobes and shifted data.
  always_comb begin
    w_in_off    = i_addr[NB_OFF-1:0];
    w_in_nbytes = 5'd1 << i_size;
    w_in_end    = 5'(w_in_off) + w_in_nbytes;
    w_in_cross  = (w_in_end > 5'(NB_BYTES));
    w_in_err    = (i_mem_read == i_mem_write) || (w_in_nbytes > 5'(NB_BYTES));
`ifndef MISALIGNED_SPLIT_EN
    w_in_err    = w_in_err || w_in_cross;
`endif
    w_in_lanes  = '0;
    for (int b = 0; b < NB_BYTES; b++) begin
      w_in_lanes[b] = (5'(b) < w_in_nbytes);
    end
    // Lanes/data beyond the first word land in the upper half (second beat).
    w_in_lanes  = w_in_lanes << w_in_off;
    w_in_wdata  = NB_WIDE'(i_write_data) << {w_in_off, 3'b000};
  end

  // Next-state logic and final-capture detection.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = i_req_valid && r_req_ready;
    w_cap_last  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_in_err ? S_RESP : S_ISSUE0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE0: begin
`ifdef MISALIGNED_SPLIT_EN
        if (r_cross) begin
          w_state_nxt = S_ISSUE1;
        end else if (r_is_load) begin
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_RESP;
        end
`else
        if (r_is_load) begin
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_RESP;
        end
`endif
      end
`ifdef MISALIGNED_SPLIT_EN
      S_ISSUE1: begin
        if (r_is_load) begin
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_RESP;
        end
      end
`endif
      S_WAIT: begin
        if (r_cnt == 2'd0) begin
          w_state_nxt = S_RESP;
          w_cap_last  = 1'b1;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

`ifdef MISALIGNED_SPLIT_EN
  // First beat of a split load arrives one cycle before the last: still in ISSUE1 when latency is 1.
  always_comb begin
    w_cap0 = r_is_load && r_cross &&
             (((r_state == S_ISSUE1) && (RD_LATENCY == 1)) ||
              ((r_state == S_WAIT) && (r_cnt == 2'd1)));
  end
`endif

  // Load formatting: align beat(s) to byte 0, keep the accessed bytes, extend the rest.
  always_comb begin
`ifdef MISALIGNED_SPLIT_EN
    w_rd_wide = r_cross ? {i_mem_rdata, r_beat0} : NB_WIDE'(i_mem_rdata);
`else
    w_rd_wide = i_mem_rdata;
`endif
    w_rd_aligned = NB_DATA'(w_rd_wide >> {r_off, 3'b000});
    w_nbytes     = 5'd1 << r_size;
    w_sign       = 1'b0;
    for (int b = 0; b < NB_BYTES; b++) begin
      w_sign = ((5'(b) + 5'd1) == w_nbytes) ? w_rd_aligned[8*b+7] : w_sign;
    end
    w_sign = w_sign & r_signed;
    for (int b = 0; b < NB_BYTES; b++) begin
      w_rd_fmt[8*b +: 8] = (5'(b) < w_nbytes) ? w_rd_aligned[8*b +: 8] : {8{w_sign}};
    end
  end

  // State register and WAIT countdown.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      if ((w_state_nxt == S_WAIT) && (r_state != S_WAIT)) begin
        r_cnt <= 2'(RD_LATENCY - 1);
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 2'd1;
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  // Request capture at acceptance; later input changes are ignored.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_is_load <= 1'b0;
      r_signed  <= 1'b0;
      r_size    <= 2'd0;
      r_off     <= '0;
`ifdef MISALIGNED_SPLIT_EN
      r_cross   <= 1'b0;
      r_waddr   <= '0;
      r_we_hi   <= '0;
      r_wd_hi   <= '0;
      r_beat0   <= '0;
`endif
    end else begin
      if (w_accept) begin
        r_is_load <= i_mem_read;
        r_signed  <= i_signed;
        r_size    <= i_size;
        r_off     <= w_in_off;
`ifdef MISALIGNED_SPLIT_EN
        r_cross   <= w_in_cross;
        r_waddr   <= i_addr[NB_ADDR-1:NB_OFF];
        r_we_hi   <= i_mem_write ? w_in_lanes[NB_WLANE-1:NB_BYTES] : '0;
        r_wd_hi   <= i_mem_write ? w_in_wdata[NB_WIDE-1:NB_DATA] : '0;
`endif
      end else begin
        r_is_load <= r_is_load;
        r_signed  <= r_signed;
        r_size    <= r_size;
        r_off     <= r_off;
      end
`ifdef MISALIGNED_SPLIT_EN
      if (w_cap0) begin
        r_beat0 <= i_mem_rdata;
      end else begin
        r_beat0 <= r_beat0;
      end
`endif
    end
  end

  // Outputs registered from the next state so each is valid for the whole state cycle.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_error     <= 1'b0;
      r_read_data <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_req_ready <= (w_state_nxt == S_IDLE);
      r_rsp_valid <= (w_state_nxt == S_RESP);
      // Only the reject path goes straight from IDLE to RESP.
      r_error     <= (w_state_nxt == S_RESP) && (r_state == S_IDLE);
      if (w_state_nxt == S_RESP) begin
        r_read_data <= w_cap_last ? w_rd_fmt : '0;
      end else begin
        r_read_data <= r_read_data;
      end
      case (w_state_nxt)
        S_ISSUE0: begin
          r_mem_en    <= 1'b1;
          r_mem_addr  <= i_addr[NB_ADDR-1:NB_OFF];
          r_mem_we    <= i_mem_write ? w_in_lanes[NB_BYTES-1:0] : '0;
          r_mem_wdata <= i_mem_write ? w_in_wdata[NB_DATA-1:0] : '0;
        end
`ifdef MISALIGNED_SPLIT_EN
        S_ISSUE1: begin
          r_mem_en    <= 1'b1;
          r_mem_addr  <= r_waddr + NB_WADDR'(1);
          r_mem_we    <= r_we_hi;
          r_mem_wdata <= r_wd_hi;
        end
`endif
        default: begin
          r_mem_en    <= 1'b0;
          r_mem_addr  <= '0;
          r_mem_we    <= '0;
          r_mem_wdata <= '0;
        end
      endcase
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_error     = r_error;
  assign o_read_data = r_read_data;
  assign o_mem_en    = r_mem_en;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;

endmodule
